// File: rtl/pll_sequencer.sv
// PLL bring-up sequencer: reset hold, lock wait with timeout, lock qualification, run and retry handling.
// Optional PLL_SEQ_BYPASS_FALLBACK_EN: once retries are exhausted, fall back to PLL bypass instead of parking in FAULT.
module pll_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_resetb,
  output logic       pll_bypass,
  output logic       ready,
  output logic [2:0] state,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAULT  = 3'd4,
    ST_BYPASS = 3'd5
  } state_t;

  localparam logic [15:0] RST_LAST     = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);
  localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRIES);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [3:0]  retry_reg, retry_next, retry_inc;
  logic [7:0]  loss_cnt_reg;
  logic        loss_inc;
  logic        sync1_reg, lock_s;
  logic        enter;

  // {pll_resetb, pll_bypass, ready} for a given state
  function automatic logic [2:0] outs(input state_t s);
    case (s)
      ST_WAIT, ST_STABLE: outs = 3'b100;
      ST_RUN:             outs = 3'b101;
      ST_BYPASS:          outs = 3'b011;
      default:            outs = 3'b000;
    endcase
  endfunction

  always_comb begin
    state_next = state_reg;
    retry_next = retry_reg;
    retry_inc  = retry_reg + 4'd1;
    loss_inc   = 1'b0;
    if (relock_req) begin
      state_next = ST_HOLD;
      retry_next = 4'd0;
    end else begin
      case (state_reg)
        ST_HOLD: if (cnt_reg == RST_LAST) state_next = ST_WAIT;
        ST_WAIT: begin
          if (lock_s)                        state_next = ST_STABLE;
          else if (cnt_reg == TIMEOUT_LAST)  state_next = ST_FAULT;
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_next = ST_WAIT;
          end else if (cnt_reg == STABLE_LAST) begin
            state_next = ST_RUN;
            retry_next = 4'd0;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_next = ST_HOLD;
            loss_inc   = 1'b1;
          end
        end
        ST_FAULT: begin
          // An exhausted retry count parks here until relock_req or reset.
          if (retry_reg < RETRY_LIMIT) begin
            retry_next = retry_inc;
            if (retry_inc < RETRY_LIMIT) state_next = ST_HOLD;
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
            else                         state_next = ST_BYPASS;
`else
            else                         state_next = ST_FAULT;
`endif
          end
        end
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
        ST_BYPASS: state_next = ST_BYPASS;
`endif
        default: state_next = ST_HOLD;
      endcase
    end
  end

  assign enter    = relock_req || (state_next != state_reg);
  assign cnt_next = enter ? 16'd0 : cnt_reg + 16'd1;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync1_reg    <= 1'b0;
      lock_s       <= 1'b0;
      state_reg    <= ST_HOLD;
      cnt_reg      <= 16'd0;
      retry_reg    <= 4'd0;
      loss_cnt_reg <= 8'd0;
      pll_resetb   <= 1'b0;
      pll_bypass   <= 1'b0;
      ready        <= 1'b0;
    end else begin
      sync1_reg <= pll_lock;
      lock_s    <= sync1_reg;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      retry_reg <= retry_next;
      if (loss_inc && (loss_cnt_reg != 8'hFF)) loss_cnt_reg <= loss_cnt_reg + 8'd1;
      {pll_resetb, pll_bypass, ready} <= outs(state_next);
    end
  end

  assign state         = state_reg;
  assign lock_loss_cnt = loss_cnt_reg;

endmodule

// File: tb/tb_pll_sequencer.sv
// Directed bench for pll_sequencer with RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
module tb_pll_sequencer;

  localparam logic [2:0] S_HOLD = 3'd0, S_WAIT = 3'd1, S_STABLE = 3'd2, S_RUN = 3'd3,
                         S_FAULT = 3'd4, S_BYPASS = 3'd5;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       pll_lock = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_resetb, pll_bypass, ready;
  logic [2:0] state;
  logic [7:0] lock_loss_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       lk;
    logic       rq;
    logic [2:0] st;
    logic       prb;
    logic       byp;
    logic       rdy;
  } vec_t;

  vec_t vecs[$];

  pll_sequencer #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .MAX_RETRIES(2)
  ) dut (
    .clk(clk), .resetb(resetb), .pll_lock(pll_lock), .relock_req(relock_req),
    .pll_resetb(pll_resetb), .pll_bypass(pll_bypass), .ready(ready),
    .state(state), .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] st, input logic prb,
                       input logic byp, input logic rdy);
    n_cmp++;
    if ({state, pll_resetb, pll_bypass, ready} !== {st, prb, byp, rdy}) begin
      n_bad++;
      $display("FAIL %s: got state=%0d resetb=%b bypass=%b ready=%b, want state=%0d resetb=%b bypass=%b ready=%b",
               name, state, pll_resetb, pll_bypass, ready, st, prb, byp, rdy);
    end else begin
      $display("ok   %s: state=%0d resetb=%b bypass=%b ready=%b", name, state, pll_resetb, pll_bypass, ready);
    end
  endtask

  task automatic check_cnt(input string name, input logic [7:0] exp);
    n_cmp++;
    if (lock_loss_cnt !== exp) begin
      n_bad++;
      $display("FAIL %s: got lock_loss_cnt=%0d, want %0d", name, lock_loss_cnt, exp);
    end else begin
      $display("ok   %s: lock_loss_cnt=%0d", name, lock_loss_cnt);
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string name);
    int i = 0;
    while (state !== st && i < budget) begin
      tick();
      i++;
    end
    n_cmp++;
    if (state !== st) begin
      n_bad++;
      $display("FAIL %s: got state=%0d after %0d cycles, want %0d", name, state, budget, st);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   bad0;

    // Nominal bring-up: pll_lock rises before edge 10 after reset release.
    for (int i = 1; i <= 21; i++) begin
      v.lk = (i >= 10);
      v.rq = 1'b0;
      if (i <= 3)       begin v.st = S_HOLD;   v.prb = 1'b0; v.byp = 1'b0; v.rdy = 1'b0; end
      else if (i <= 11) begin v.st = S_WAIT;   v.prb = 1'b1; v.byp = 1'b0; v.rdy = 1'b0; end
      else if (i <= 19) begin v.st = S_STABLE; v.prb = 1'b1; v.byp = 1'b0; v.rdy = 1'b0; end
      else              begin v.st = S_RUN;    v.prb = 1'b1; v.byp = 1'b0; v.rdy = 1'b1; end
      vecs.push_back(v);
    end

    // Reset state
    tick();
    tick();
    check("reset_outputs", S_HOLD, 1'b0, 1'b0, 1'b0);
    check_cnt("reset_loss_cnt", 8'd0);

    resetb = 1'b1;
    foreach (vecs[i]) begin
      pll_lock   = vecs[i].lk;
      relock_req = vecs[i].rq;
      tick();
      check($sformatf("nominal_edge%0d", i + 1), vecs[i].st, vecs[i].prb, vecs[i].byp, vecs[i].rdy);
    end
    check_cnt("nominal_loss_cnt", 8'd0);

    // Three lock losses in RUN
    for (int k = 1; k <= 3; k++) begin
      pll_lock = 1'b0;
      tick();
      tick();
      check($sformatf("loss%0d_sync_delay", k), S_RUN, 1'b1, 1'b0, 1'b1);
      tick();
      check($sformatf("loss%0d_hold", k), S_HOLD, 1'b0, 1'b0, 1'b0);
      check_cnt($sformatf("loss%0d_cnt", k), 8'(k));
      pll_lock = 1'b1;
      wait_state(S_RUN, 30, $sformatf("loss%0d_rerun", k));
    end

    // relock_req in RUN, then a one-cycle lock glitch during STABLE
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    check("relock_run_hold", S_HOLD, 1'b0, 1'b0, 1'b0);
    check_cnt("relock_keeps_cnt", 8'd3);
    repeat (4) tick();
    check("relock_hold_len", S_WAIT, 1'b1, 1'b0, 1'b0);
    tick();
    check("relock_stable", S_STABLE, 1'b1, 1'b0, 1'b0);
    repeat (2) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    tick();
    check("glitch_pre", S_STABLE, 1'b1, 1'b0, 1'b0);
    tick();
    check("glitch_to_wait", S_WAIT, 1'b1, 1'b0, 1'b0);
    tick();
    check("glitch_restable", S_STABLE, 1'b1, 1'b0, 1'b0);
    repeat (7) tick();
    check("glitch_7th", S_STABLE, 1'b1, 1'b0, 1'b0);
    tick();
    check("glitch_run", S_RUN, 1'b1, 1'b0, 1'b1);

    // Drive lock_loss_cnt to saturation
    bad0 = n_bad;
    for (int k = 4; k <= 256; k++) begin
      pll_lock = 1'b0;
      wait_state(S_HOLD, 10, "sat_loss");
      pll_lock = 1'b1;
      wait_state(S_RUN, 30, "sat_rerun");
      if (k == 255) check_cnt("cnt_reaches_255", 8'd255);
      if (n_bad != bad0) break;
    end
    check_cnt("cnt_saturated", 8'd255);

    // Lock timeout: two FAULT passes, then fallback
    pll_lock = 1'b0;
    repeat (3) tick();
    check("to_hold", S_HOLD, 1'b0, 1'b0, 1'b0);
    check_cnt("to_cnt_sat", 8'd255);
    repeat (4) tick();
    check("to_wait", S_WAIT, 1'b1, 1'b0, 1'b0);
    repeat (19) tick();
    check("to_wait_last", S_WAIT, 1'b1, 1'b0, 1'b0);
    tick();
    check("to_fault1", S_FAULT, 1'b0, 1'b0, 1'b0);
    tick();
    check("to_retry_hold", S_HOLD, 1'b0, 1'b0, 1'b0);
    repeat (24) tick();
    check("to_fault2", S_FAULT, 1'b0, 1'b0, 1'b0);
    tick();
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
    check("to_exhausted", S_BYPASS, 1'b0, 1'b1, 1'b1);
    repeat (10) tick();
    check("to_exhausted_stays", S_BYPASS, 1'b0, 1'b1, 1'b1);
`else
    check("to_exhausted", S_FAULT, 1'b0, 1'b0, 1'b0);
    repeat (10) tick();
    check("to_exhausted_stays", S_FAULT, 1'b0, 1'b0, 1'b0);
`endif

    // relock_req from the exhausted state clears the retry count
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    check("relock_exh_hold", S_HOLD, 1'b0, 1'b0, 1'b0);
    repeat (24) tick();
    check("relock_exh_fault1", S_FAULT, 1'b0, 1'b0, 1'b0);
    tick();
    check("retry_cleared_hold", S_HOLD, 1'b0, 1'b0, 1'b0);
    repeat (25) tick();
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
    check("relock_exh_again", S_BYPASS, 1'b0, 1'b1, 1'b1);
`else
    check("relock_exh_again", S_FAULT, 1'b0, 1'b0, 1'b0);
`endif
    pll_lock   = 1'b1;
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    check("relock_lock_hold", S_HOLD, 1'b0, 1'b0, 1'b0);
    repeat (12) tick();
    check("relock_lock_stable", S_STABLE, 1'b1, 1'b0, 1'b0);
    tick();
    check("relock_lock_run", S_RUN, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset in the middle of WAIT
    pll_lock   = 1'b0;
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    repeat (6) tick();
    check("mid_wait", S_WAIT, 1'b1, 1'b0, 1'b0);
    #2;
    resetb = 1'b0;
    #1;
    check("async_reset_outputs", S_HOLD, 1'b0, 1'b0, 1'b0);
    check_cnt("async_reset_cnt", 8'd0);
    tick();
    resetb = 1'b1;
    repeat (3) tick();
    check("post_reset_hold", S_HOLD, 1'b0, 1'b0, 1'b0);
    tick();
    check("post_reset_wait", S_WAIT, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pll_sequencer.md
PLL_SEQUENCER -- requirements
Module: pll_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: clk cycles pll_resetb is held low per attempt (1..65535).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 4096: clk cycles allowed in WAIT before fault (1..65535).
REQ-003 SHALL have parameter STABLE_CYCLES, default 256: consecutive synced-lock cycles required before RUN (1..65535).
REQ-004 SHALL have parameter MAX_RETRIES, default 3: faults tolerated before giving up (1..15).
REQ-005 clk  input  1  reference clock, the same clock that feeds the PLL REFERENCECLK; one clock domain, all logic on its rising edge.
REQ-006 resetb  input  1  asynchronous, active-low reset.
REQ-007 pll_lock  input  1  PLL LOCK output, asynchronous to clk.
REQ-008 relock_req  input  1  single-cycle request to restart the sequence.
REQ-009 pll_resetb  output  1  drives the PLL RESETB pin.
REQ-010 pll_bypass  output  1  drives the PLL BYPASS pin.
REQ-011 ready  output  1  high when the downstream clock is usable.
REQ-012 state  output  3  current state encoding.
REQ-013 lock_loss_cnt  output  8  count of lock losses seen in RUN.

Function
REQ-014 SHALL synchronise pll_lock through two flops to lock_s; all decisions SHALL use lock_s only.
REQ-015 SHALL implement states HOLD=0, WAIT=1, STABLE=2, RUN=3, FAULT=4, BYPASS=5; codes 6 and 7 SHALL go to HOLD.
REQ-016 SHALL use one 16-bit cycle counter, cleared on every state entry.
REQ-017 HOLD: pll_resetb=0, pll_bypass=0, ready=0; after exactly RST_CYCLES cycles SHALL go to WAIT.
REQ-018 WAIT: pll_resetb=1; lock_s=1 SHALL go to STABLE; counter reaching LOCK_TIMEOUT-1 with lock_s=0 SHALL go to FAULT.
REQ-019 STABLE: lock_s=0 SHALL go to WAIT (timeout restarts); STABLE_CYCLES consecutive lock_s=1 cycles SHALL go to RUN.
REQ-020 RUN: ready=1; lock_s=0 SHALL go to HOLD, deassert ready on the same edge, and increment lock_loss_cnt, saturating at 255.
REQ-021 FAULT: lasts one cycle and increments a 4-bit retry count; retry count below MAX_RETRIES SHALL go to HOLD, otherwise per REQ-027/028.
REQ-022 Entry to RUN SHALL clear the retry count.
REQ-023 relock_req=1 in any state SHALL go to HOLD and clear the retry count, with priority over every other transition; lock_loss_cnt is unchanged.
REQ-024 pll_resetb, pll_bypass, ready and state SHALL be registered outputs, with no combinational path from inputs.

Reset
REQ-025 resetb=0 SHALL asynchronously force state=HOLD, counter=0, retry count=0, lock_loss_cnt=0, sync flops=0, pll_resetb=0, pll_bypass=0, ready=0.
REQ-026 Reset deassertion SHALL start a full HOLD period; assertion mid-sequence SHALL abort any state immediately.

Configuration
REQ-027 With PLL_SEQ_BYPASS_FALLBACK_EN defined, exhausted retries SHALL go from FAULT to BYPASS: pll_bypass=1, pll_resetb=0, ready=1; BYPASS is left only by relock_req or reset.
REQ-028 Without PLL_SEQ_BYPASS_FALLBACK_EN, exhausted retries SHALL keep the block in FAULT with ready=0, pll_resetb=0, pll_bypass=0; FAULT is left only by relock_req or reset; BYPASS is unreachable and code 5 is treated as an illegal state.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-029 Nominal lock: release resetb, raise pll_lock 10 cycles later -> pll_resetb=1 from cycle 4; ready=1 on the 8th lock_s cycle in STABLE; state=3.
REQ-030 Glitchy lock: drop pll_lock for 1 cycle during STABLE -> return to WAIT; RUN only after 8 further consecutive lock_s cycles.
REQ-031 Lock loss: drop pll_lock in RUN three times -> each loss deasserts ready and reruns HOLD; lock_loss_cnt=3; a forced 255 stays at 255.
REQ-032 Timeout: pll_lock held 0 -> two FAULT passes, then BYPASS with ready=1, pll_bypass=1 when the macro is defined; stuck in FAULT with ready=0 when undefined.
REQ-033 relock_req pulse in RUN and in BYPASS/FAULT -> HOLD on the next edge, retry count 0, full sequence repeats.
REQ-034 resetb asserted mid-WAIT -> outputs at reset values asynchronously, before the next clk edge.
